// File: rtl/signed_pow2_divide_sequencer.sv
// Signed right shift of an N-bit operand by a run-time amount, one bit per clock.
// Mode 0 floors (plain arithmetic shift). Mode 1 truncates toward zero, like C
// division by 2^s. The bits shifted out are tracked so that a negative operand
// with a nonzero remainder can be nudged up by one at the end.
module signed_pow2_divide_sequencer #(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shift,
    input  logic          up_mode,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data,
    output logic          down_inexact
);

    // The step counter must be able to hold every value from 0 to N inclusive.
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] OUT   = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          sticky;
    logic          neg;
    logic          mode;
    logic [31:0]   shift_wide;
    logic [CW-1:0] shift_clamped;
    logic          correct;

    // Shifting N or more places gives the same result as exactly N steps, so
    // larger amounts are clamped and the sequence never runs longer than N steps.
    always_comb begin
        shift_wide    = 32'(up_shift);
        shift_clamped = CW'(N);
        if (shift_wide < 32'(N)) begin
            shift_clamped = CW'(up_shift);
        end
    end

    // Handshake outputs and the toward-zero correction are decoded from registered state.
    always_comb begin
        up_ready   = (state == IDLE);
        down_valid = (state == OUT);
        correct    = mode && neg && sticky;
    end

    // Main sequencer: accept a request, shift one bit per clock, then present the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            sticky       <= 1'b0;
            neg          <= 1'b0;
            mode         <= 1'b0;
            down_data    <= '0;
            down_inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (up_valid) begin
                        acc    <= up_data;
                        cnt    <= shift_clamped;
                        sticky <= 1'b0;
                        neg    <= up_data[N-1];
                        mode   <= up_mode;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        sticky <= sticky | acc[0];
                        acc    <= {acc[N-1], acc[N-1:1]};
                        cnt    <= cnt - CW'(1);
                    end else begin
                        down_data    <= acc + {{(N-1){1'b0}}, correct};
                        down_inexact <= sticky;
                        state        <= OUT;
                    end
                end
                OUT: begin
                    if (down_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_pow2_divide_sequencer.sv
// Directed bench for signed_pow2_divide_sequencer with hand-computed expected results.
// A 4-bit shift field is used so that amounts above N can be applied.
module tb_signed_pow2_divide_sequencer;

    logic       clk;
    logic       rst;
    logic       up_valid;
    logic       up_ready;
    logic [7:0] up_data;
    logic [3:0] up_shift;
    logic       up_mode;
    logic       down_valid;
    logic       down_ready;
    logic [7:0] down_data;
    logic       down_inexact;

    int checks;
    int failures;

    signed_pow2_divide_sequencer #(.N(8), .SW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .up_data      (up_data),
        .up_shift     (up_shift),
        .up_mode      (up_mode),
        .down_valid   (down_valid),
        .down_ready   (down_ready),
        .down_data    (down_data),
        .down_inexact (down_inexact)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one request, measure cycles from accept to down_valid, then drain the result.
    // A latency of -1 means the request was never accepted or never completed.
    task automatic run_op(input logic [7:0] data, input logic [3:0] shamt, input logic md,
                          output logic [7:0] res, output logic inx, output int lat);
        int waited;
        lat = -1;
        res = 8'h00;
        inx = 1'b0;
        waited = 0;
        while (!up_ready && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!up_ready) return;
        up_valid = 1'b1;
        up_data  = data;
        up_shift = shamt;
        up_mode  = md;
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (down_valid) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) return;
        res = down_data;
        inx = down_inexact;
        down_ready = 1'b1;
        @(posedge clk);
        #1;
        down_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        up_valid = 1'b0;
        up_data = 8'h00;
        up_shift = 4'd0;
        up_mode = 1'b0;
        down_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (up_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_up_ready got=%b exp=1", up_ready); end
        checks++;
        if (down_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_down_valid got=%b exp=0", down_valid); end
        checks++;
        if (down_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_down_data got=%h exp=00", down_data); end
        checks++;
        if (down_inexact !== 1'b0) begin failures++; $display("[TB] FAIL reset_inexact got=%b exp=0", down_inexact); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_floor();
        logic [7:0] r;
        logic i;
        int l;
        run_op(8'h94, 4'd2, 1'b0, r, i, l);
        checks++;
        if (l !== 3) begin failures++; $display("[TB] FAIL floor_latency got=%0d exp=3", l); end
        checks++;
        if (r !== 8'hE5) begin failures++; $display("[TB] FAIL floor_data got=%h exp=e5", r); end
        checks++;
        if (i !== 1'b0) begin failures++; $display("[TB] FAIL floor_inexact got=%b exp=0", i); end
    endtask

    task automatic test_trunc();
        logic [7:0] r;
        logic i;
        int l;
        run_op(8'hF9, 4'd1, 1'b0, r, i, l);
        checks++;
        if (r !== 8'hFC || i !== 1'b1) begin failures++; $display("[TB] FAIL m0_neg7 got=%h/%b exp=fc/1", r, i); end
        run_op(8'hF9, 4'd1, 1'b1, r, i, l);
        checks++;
        if (r !== 8'hFD || i !== 1'b1) begin failures++; $display("[TB] FAIL m1_neg7 got=%h/%b exp=fd/1", r, i); end
        checks++;
        if (l !== 2) begin failures++; $display("[TB] FAIL m1_neg7_latency got=%0d exp=2", l); end
        run_op(8'h07, 4'd1, 1'b1, r, i, l);
        checks++;
        if (r !== 8'h03 || i !== 1'b1) begin failures++; $display("[TB] FAIL m1_pos7 got=%h/%b exp=03/1", r, i); end
    endtask

    task automatic test_zero_and_full_shift();
        logic [7:0] r;
        logic i;
        int l;
        run_op(8'h80, 4'd0, 1'b0, r, i, l);
        checks++;
        if (r !== 8'h80 || i !== 1'b0 || l !== 1) begin failures++; $display("[TB] FAIL s0_m0 got=%h/%b/%0d exp=80/0/1", r, i, l); end
        run_op(8'h80, 4'd0, 1'b1, r, i, l);
        checks++;
        if (r !== 8'h80 || i !== 1'b0 || l !== 1) begin failures++; $display("[TB] FAIL s0_m1 got=%h/%b/%0d exp=80/0/1", r, i, l); end
        run_op(8'h80, 4'd7, 1'b1, r, i, l);
        checks++;
        if (r !== 8'hFF || i !== 1'b0 || l !== 8) begin failures++; $display("[TB] FAIL s7_m1 got=%h/%b/%0d exp=ff/0/8", r, i, l); end
    endtask

    task automatic test_clamp();
        logic [7:0] r;
        logic i;
        int l;
        run_op(8'hF9, 4'd12, 1'b0, r, i, l);
        checks++;
        if (r !== 8'hFF || i !== 1'b1) begin failures++; $display("[TB] FAIL clamp_m0_neg got=%h/%b exp=ff/1", r, i); end
        checks++;
        if (l !== 9) begin failures++; $display("[TB] FAIL clamp_latency got=%0d exp=9", l); end
        run_op(8'hF9, 4'd12, 1'b1, r, i, l);
        checks++;
        if (r !== 8'h00 || i !== 1'b1) begin failures++; $display("[TB] FAIL clamp_m1_neg got=%h/%b exp=00/1", r, i); end
        run_op(8'h7F, 4'd12, 1'b0, r, i, l);
        checks++;
        if (r !== 8'h00 || i !== 1'b1) begin failures++; $display("[TB] FAIL clamp_m0_pos got=%h/%b exp=00/1", r, i); end
    endtask

    task automatic test_backpressure();
        int seen;
        seen = 0;
        up_valid = 1'b1;
        up_data  = 8'h94;
        up_shift = 4'd2;
        up_mode  = 1'b1;
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        for (int c = 0; c < 20 && !down_valid; c++) begin
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 5; c++) begin
            up_valid = ~up_valid;
            up_data  = 8'h11 + 8'(c);
            @(posedge clk);
            #1;
            if (down_valid && !up_ready && down_data === 8'hE5 && down_inexact === 1'b0) seen++;
        end
        checks++;
        if (seen !== 5) begin failures++; $display("[TB] FAIL stall_hold got=%0d exp=5 stable cycles", seen); end
        up_valid   = 1'b1;
        up_data    = 8'h07;
        up_shift   = 4'd0;
        up_mode    = 1'b0;
        down_ready = 1'b1;
        @(posedge clk);
        #1;
        down_ready = 1'b0;
        checks++;
        if (up_ready !== 1'b1 || down_valid !== 1'b0) begin failures++; $display("[TB] FAIL release_idle got=%b/%b exp=1/0", up_ready, down_valid); end
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        checks++;
        if (up_ready !== 1'b0 || down_valid !== 1'b0) begin failures++; $display("[TB] FAIL late_accept got=%b/%b exp=0/0", up_ready, down_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (down_valid !== 1'b1 || down_data !== 8'h07) begin failures++; $display("[TB] FAIL late_result got=%b/%h exp=1/07", down_valid, down_data); end
        down_ready = 1'b1;
        @(posedge clk);
        #1;
        down_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [7:0] r;
        logic i;
        int l;
        int bad;
        bad = 0;
        up_valid = 1'b1;
        up_data  = 8'hF9;
        up_shift = 4'd5;
        up_mode  = 1'b0;
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (up_ready !== 1'b1 || down_valid !== 1'b0 || down_data !== 8'h00 || down_inexact !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_outputs got=%b/%b/%h/%b exp=1/0/00/0", up_ready, down_valid, down_data, down_inexact);
        end
        #2;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (down_valid || !up_ready) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("[TB] FAIL abort_no_pulse got=%0d exp=0 bad cycles", bad); end
        run_op(8'h94, 4'd2, 1'b0, r, i, l);
        checks++;
        if (r !== 8'hE5 || i !== 1'b0 || l !== 3) begin failures++; $display("[TB] FAIL after_abort got=%h/%b/%0d exp=e5/0/3", r, i, l); end
    endtask

    // Run every scenario in order, then print the summary line.
    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_floor();
        test_trunc();
        test_zero_and_full_shift();
        test_clamp();
        test_backpressure();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
